alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares a single 32-bit ALU among NREQ requesters.
//  Each requester issues {a, b, op} over a valid/ready handshake. The grant is held
//  through execute and response, and the registered result is returned to the winning requester.
//  Sits between the issue agents (core execute path, address-gen, debug unit) and one alu instance.
// PARAMETERS
//  NREQ   2   number of requesters (2..8); IDW = $clog2(NREQ) is a derived localparam
// PORTS
//  i_clk          in   1          clock, all state on rising edge
//  i_rst_n        in   1          asynchronous active-low reset
//  i_req_valid    in   NREQ       per-requester request valid
//  o_req_ready    out  NREQ       per-requester accept (one-hot or zero)
//  i_req_a        in   NREQ*32    operand A, requester k at [32k+:32]
//  i_req_b        in   NREQ*32    operand B, requester k at [32k+:32]
//  i_req_op       in   NREQ*3     ALU control, requester k at [3k+:3]
//  o_rsp_valid    out  NREQ       response valid, one-hot to owning requester
//  i_rsp_ready    in   NREQ       per-requester response accept
//  o_rsp_result   out  32         registered ALU result
//  o_rsp_zero     out  1          registered zero flag
//  o_rsp_err      out  1          op was not in {000,001,010,011,101}
//  o_busy         out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, rr_ptr=0, all outputs 0, operand regs 0.
//  - FSM IDLE -> EXEC -> RESP -> IDLE. One transaction in flight.
//    Throughput is 1 op per 3 cycles when responses are accepted immediately.
//  - IDLE: the winner is the first k with i_req_valid[k], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//    o_req_ready[winner]=1 (combinational on i_req_valid); all other ready bits are 0.
//    On handshake: latch a, b, op and owner id; go to EXEC; rr_ptr <= (winner+1) mod NREQ.
//    No valid request: stay in IDLE; rr_ptr is unchanged.
//  - EXEC: alu driven from the latched operands. Capture result, zero flag, and err=(op illegal).
//    Go to RESP.
//  - RESP: o_rsp_valid[owner]=1; result, zero and err held stable.
//    On i_rsp_ready[owner] go to IDLE. i_rsp_ready of non-owners is ignored.
//  - Latency: request handshake in cycle N gives o_rsp_valid in cycle N+2.
//    The earliest next accept is cycle N+3.
//  - o_req_ready is 0 in EXEC and RESP. Requesters must hold valid and payload until ready.
//    A valid dropped before grant is not an error: that requester simply loses the turn.
//  - Illegal op: still executed. Result = alu default (32'hDEADBEEF), zero=0, o_rsp_err=1.
//  - Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0,...
//    No requester waits more than NREQ-1 transactions.
//  - Reset mid-operation: the in-flight transaction is dropped, no response is produced,
//    and rr_ptr returns to 0.
//  - Width: operands and result are fixed at 32 bits; wrap-around is the alu's modulo-2^32
//    arithmetic, and no overflow flag is produced.
// STRUCTURE
//  - alu_pkg: alucontrol localparams (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011,
//    ALU_SLT=101), function is_legal_op(), typedef enum {IDLE, EXEC, RESP} arb_state_t.
//  - One sub-module instance, alu (u_alu), fed from the operand registers.
//  - Round-robin pick is a combinational function in this module (rotate, priority-encode,
//    un-rotate); no separate arbiter module.
// TESTING
//  1. req0 a=5 b=7 op=000, rsp_ready=1 -> ready0 in cycle N; rsp_valid=01, result=12,
//     zero=0 in cycle N+2.
//  2. req1 a=7 b=7 op=001 -> result=0, zero=1, rsp_valid=10, err=0.
//  3. Both valid continuously, NREQ=2 -> grant order 0,1,0,1.
//     req0 a=3 b=9 op=101 -> result=1; req1 a=0xF0 b=0x0F op=011 -> result=0xFF.
//  4. Response backpressure: hold rsp_ready0=0 for 5 cycles -> rsp_valid, result and zero stable.
//     o_req_ready=0 throughout; IDLE entered the cycle after rsp_ready0=1.
//  5. req0 op=111 a=1 b=2 -> result=32'hDEADBEEF, zero=0, err=1; the next legal op gives err=0.
//  6. Assert i_rst_n=0 during EXEC -> outputs 0 immediately (async).
//     After release: no rsp_valid, first grant to req0 with both valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, legality check and arbiter FSM state type.
// Used by the ALU datapath and the round-robin arbiter that feeds it.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [31:0] ALU_DEFAULT_RESULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: add, sub, and, or, signed set-less-than.
// Unknown control codes produce a recognisable default pattern.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_result,
  output logic        o_zero
);

  logic [31:0] w_result;

  always_comb begin
    w_result = ALU_DEFAULT_RESULT;
    case (i_op)
      ALU_ADD: w_result = i_a + i_b;
      ALU_SUB: w_result = i_a - i_b;
      ALU_AND: w_result = i_a & i_b;
      ALU_OR:  w_result = i_a | i_b;
      ALU_SLT: w_result = {31'b0, ($signed(i_a) < $signed(i_b))};
      default: w_result = ALU_DEFAULT_RESULT;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*32-1:0] i_req_a,
  input  logic [NREQ*32-1:0] i_req_b,
  input  logic [NREQ*3-1:0] i_req_op,
  output logic [NREQ-1:0]   o_rsp_valid,
  input  logic [NREQ-1:0]   i_rsp_ready,
  output logic [31:0]       o_rsp_result,
  output logic              o_rsp_zero,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_owner;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [2:0]      r_op;
  logic [31:0]     r_result;
  logic            r_zero;
  logic            r_err;
  logic [NREQ-1:0] r_rsp_valid;
  logic            r_busy;

  logic [IDW-1:0]  w_winner;
  logic [IDW-1:0]  w_next_ptr;
  logic            w_any_valid;
  logic [NREQ-1:0] w_req_ready;
  logic [31:0]     w_alu_result;
  logic            w_alu_zero;

  // Search order ptr, ptr+1, ... : walking the offsets downward lets the
  // smallest offset overwrite, i.e. rotate + priority-encode + un-rotate.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] pick;
    int             idx;
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (valid[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    w_any_valid = |i_req_valid;
    w_winner    = rr_pick(i_req_valid, r_rr_ptr);
    w_next_ptr  = IDW'((int'(w_winner) + 1) % NREQ);
  end

  // Ready is masked by reset so every output reads zero while reset is held.
  always_comb begin
    w_req_ready = '0;
    if (i_rst_n && (r_state == IDLE) && w_any_valid) w_req_ready[w_winner] = 1'b1;
  end

  alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_a      <= i_req_a[32*w_winner +: 32];
            r_b      <= i_req_b[32*w_winner +: 32];
            r_op     <= i_req_op[3*w_winner +: 3];
            r_owner  <= w_winner;
            r_rr_ptr <= w_next_ptr;
            r_busy   <= 1'b1;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_result    <= w_alu_result;
          r_zero      <= w_alu_zero;
          r_err       <= !is_legal_op(r_op);
          r_rsp_valid <= NREQ'(1) << r_owner;
          r_state     <= RESP;
        end
        RESP: begin
          // Only the owner's accept retires the response.
          if (i_rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_result;
  assign o_rsp_zero   = r_zero;
  assign o_rsp_err    = r_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table plus hand-written multi-cycle sequences,
// with responses checked against an expected-result queue.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 42; // {owner[7:0], result[31:0], zero, err}

  logic              i_clk;
  logic              i_rst_n;
  logic [NREQ-1:0]   i_req_valid;
  logic [NREQ-1:0]   o_req_ready;
  logic [NREQ*32-1:0] i_req_a;
  logic [NREQ*32-1:0] i_req_b;
  logic [NREQ*3-1:0] i_req_op;
  logic [NREQ-1:0]   o_rsp_valid;
  logic [NREQ-1:0]   i_rsp_ready;
  logic [31:0]       o_rsp_result;
  logic              o_rsp_zero;
  logic              o_rsp_err;
  logic              o_busy;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .i_req_op     (i_req_op),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_result (o_rsp_result),
    .o_rsp_zero   (o_rsp_zero),
    .o_rsp_err    (o_rsp_err),
    .o_busy       (o_busy)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           hs_q[$];
  int           checks   = 0;
  int           failures = 0;
  bit           rsp_seen = 0;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] result;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input int owner, input logic [31:0] res,
                                            input logic zero, input logic err);
    return {8'(owner), res, zero, err};
  endfunction

  // Reference ALU written from the operation list.
  function automatic logic [W-1:0] model(input int owner, input logic [31:0] a,
                                         input logic [31:0] b, input logic [2:0] op);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin r = 32'hDEADBEEF; e = 1'b1; end
    endcase
    return pack_exp(owner, r, (r == 32'd0), e);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    logic [W-1:0] e;
    if (!i_rst_n) begin
      hs_q.delete();
      rsp_seen = 0;
    end else begin
      if ((o_req_ready & i_req_valid) != '0) hs_q.push_back(cyc);
      if (o_rsp_valid != '0 && !rsp_seen) begin
        rsp_seen = 1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=rsp_valid %b required=none", o_rsp_valid);
        end else begin
          e = exp_q.pop_front();
          check("rsp_valid",  32'(o_rsp_valid), 32'(NREQ'(1) << e[41:34]));
          check("rsp_result", o_rsp_result, e[33:2]);
          check("rsp_zero",   32'(o_rsp_zero), 32'(e[1]));
          check("rsp_err",    32'(o_rsp_err),  32'(e[0]));
          if (hs_q.size() != 0) check("rsp_latency", 32'(cyc - hs_q.pop_front()), 32'd2);
        end
      end
      if ((o_rsp_valid & i_rsp_ready) != '0) rsp_seen = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    i_req_a[32*k +: 32] = a;
    i_req_b[32*k +: 32] = b;
    i_req_op[3*k +: 3]  = op;
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    bit got;
    got = 0;
    @(posedge i_clk); #1;
    set_req(k, a, b, op);
    i_req_valid[k] = 1'b1;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge i_clk);
      if (o_req_ready[k]) got = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL grant_timeout actual=no ready required=ready%0d", k);
    end
    @(posedge i_clk); #1;
    i_req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_busy) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=pending=%0d busy=%0b required=idle", exp_q.size(), o_busy);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, last;
    bit got;
    int k;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    vecs[0]  = '{0, 32'd5,        32'd7,        3'b000, 32'd12,         1'b0, 1'b0};
    vecs[1]  = '{1, 32'd7,        32'd7,        3'b001, 32'd0,          1'b1, 1'b0};
    vecs[2]  = '{0, 32'd1,        32'd2,        3'b111, 32'hDEADBEEF,   1'b0, 1'b1};
    vecs[3]  = '{1, 32'd4,        32'd3,        3'b000, 32'd7,          1'b0, 1'b0};
    vecs[4]  = '{0, 32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,          1'b1, 1'b0};
    vecs[5]  = '{1, 32'd0,        32'd1,        3'b001, 32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[6]  = '{0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b010, 32'hF000F000,   1'b0, 1'b0};
    vecs[7]  = '{1, 32'hFFFFFFFF, 32'd1,        3'b101, 32'd1,          1'b0, 1'b0};
    vecs[8]  = '{0, 32'd1,        32'hFFFFFFFF, 3'b101, 32'd0,          1'b1, 1'b0};
    vecs[9]  = '{1, 32'd8,        32'd9,        3'b100, 32'hDEADBEEF,   1'b0, 1'b1};
    vecs[10] = '{0, 32'd8,        32'd9,        3'b110, 32'hDEADBEEF,   1'b0, 1'b1};

    i_rst_n     = 1'b0;
    i_req_valid = '0;
    i_req_a     = '0;
    i_req_b     = '0;
    i_req_op    = '0;
    i_rsp_ready = '1;

    // Reset state, including ready masked while reset is held.
    #1;
    i_req_valid = 2'b01;
    #1;
    check("reset_req_ready", 32'(o_req_ready), 32'd0);
    check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_result",    o_rsp_result,     32'd0);
    check("reset_zero_err",  32'({o_rsp_zero, o_rsp_err}), 32'd0);
    check("reset_busy",      32'(o_busy),      32'd0);
    i_req_valid = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Vector table, one requester at a time.
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(pack_exp(vecs[i].req, vecs[i].result, vecs[i].zero, vecs[i].err));
      issue(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].op);
      wait_idle();
    end

    // Fairness: both valid continuously, grants 0,1,0,1 spaced 3 cycles apart.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pack_exp(0, 32'd1, 1'b0, 1'b0));
      exp_q.push_back(pack_exp(1, 32'hFF, 1'b0, 1'b0));
    end
    @(posedge i_clk); #1;
    set_req(0, 32'd3, 32'd9, 3'b101);
    set_req(1, 32'hF0, 32'h0F, 3'b011);
    i_req_valid = 2'b11;
    n = 0; last = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      @(negedge i_clk);
      if ((o_req_ready & i_req_valid) != '0) begin
        check("fair_grant", 32'(o_req_ready), (n % 2 == 0) ? 32'd1 : 32'd2);
        if (n > 0) check("fair_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        n++;
      end
    end
    check("fair_count", 32'(n), 32'd4);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    wait_idle();

    // Response backpressure from requester 0; requester 1 waits and non-owner ready is ignored.
    i_rsp_ready = 2'b10;
    exp_q.push_back(pack_exp(0, 32'd7, 1'b0, 1'b0));
    exp_q.push_back(pack_exp(1, 32'd4, 1'b0, 1'b0));
    set_req(1, 32'd2, 32'd2, 3'b000);
    issue(0, 32'd10, 32'd3, 3'b001);
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge i_clk);
      if (o_rsp_valid[0]) got = 1;
    end
    check("bp_rsp_seen", 32'(got), 32'd1);
    #1 i_req_valid[1] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      check("bp_result",    o_rsp_result, 32'd7);
      check("bp_zero",      32'(o_rsp_zero), 32'd0);
      check("bp_req_ready", 32'(o_req_ready), 32'd0);
      check("bp_busy",      32'(o_busy), 32'd1);
      @(negedge i_clk);
    end
    @(posedge i_clk); #1;
    i_rsp_ready = 2'b11;
    @(negedge i_clk);
    check("bp_accept_valid", 32'(o_rsp_valid), 32'd1);
    @(negedge i_clk);
    check("bp_idle_busy",    32'(o_busy), 32'd0);
    check("bp_idle_ready",   32'(o_req_ready), 32'd2);
    check("bp_idle_rsp",     32'(o_rsp_valid), 32'd0);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    wait_idle();

    // Random transactions checked against the reference model.
    for (int i = 0; i < 8; i++) begin
      k   = $urandom_range(0, 1);
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rop = 3'($urandom_range(0, 7));
      exp_q.push_back(model(k, ra, rb, rop));
      issue(k, ra, rb, rop);
      wait_idle();
    end

    // Reset during EXEC: drop the transaction, pointer back to 0.
    @(posedge i_clk); #1;
    set_req(0, 32'd1, 32'd1, 3'b000);
    set_req(1, 32'd6, 32'd2, 3'b001);
    i_req_valid = 2'b01;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge i_clk);
      if (o_req_ready[0]) got = 1;
    end
    check("rst_pre_grant", 32'(got), 32'd1);
    @(posedge i_clk); #2;
    i_req_valid = 2'b11;
    i_rst_n     = 1'b0;
    #1;
    check("rst_busy",      32'(o_busy), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_req_ready", 32'(o_req_ready), 32'd0);
    check("rst_result",    o_rsp_result, 32'd0);
    i_req_valid = '0;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge i_clk);
      check("rst_no_rsp",  32'(o_rsp_valid), 32'd0);
      check("rst_no_busy", 32'(o_busy), 32'd0);
    end
    exp_q.push_back(pack_exp(0, 32'd2, 1'b0, 1'b0));
    @(posedge i_clk); #1;
    i_req_valid = 2'b11;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge i_clk);
      if ((o_req_ready & i_req_valid) != '0) begin
        got = 1;
        check("rst_first_grant", 32'(o_req_ready), 32'd1);
      end
    end
    check("rst_grant_seen", 32'(got), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    wait_idle();

    check("drain_exp_q", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
